spi_write_slave: RTL

Receive-side SPI write port that consumes the 16-bit CS/SCLK/SDATA write frames driven by the bench SPI master. It samples the pins with the system clock, assembles an 8-bit address and 8-bit data, and issues a one-cycle write strobe into a small on-chip register bank. Downstream logic reads the registers in parallel from `regs`.

---
 rtl/spi_write_slave.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_write_slave.sv
// SPI mode-0 write port: oversamples CS/SCLK/SDATA with clk, assembles 16-bit
// address/data frames and writes them into a parallel-readable register bank.
module spi_write_slave #(
    parameter int unsigned NREG = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_n,
    input  logic                sclk,
    input  logic                sdata,
    output logic                wr_en,
    output logic [7:0]          wr_addr,
    output logic [7:0]          wr_data,
    output logic                frame_err,
    output logic                addr_err,
    output logic [NREG*8-1:0]   regs
);

    typedef enum logic [2:0] {StWaitIdle, StIdle, StShift, StCommit, StTail} state_e;

    state_e state_q, state_d;

    // [0],[1]: synchronizer stages; [2]: delayed copy for edge detection
    logic [2:0]  cs_q, sclk_q;
    logic [1:0]  sd_q;
    logic        cs_fall, cs_rise, sclk_rise, cs_high, sd;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        tail_q, tail_d;
    logic        wr_en_q, wr_en_d, ferr_q, ferr_d, aerr_q, aerr_d;
    logic [7:0]  wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic        reg_we, addr_ok;
    logic [NREG*8-1:0] regs_q;

    // Sync cs_n resets low so a frame in progress at reset release is never seen as a CS fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= 3'b000;
            sclk_q <= 3'b000;
            sd_q   <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], cs_n};
            sclk_q <= {sclk_q[1:0], sclk};
            sd_q   <= {sd_q[0], sdata};
        end
    end

    assign cs_high   = cs_q[1];
    assign cs_fall   = !cs_q[1] && cs_q[2];
    assign cs_rise   = cs_q[1] && !cs_q[2];
    assign sclk_rise = sclk_q[1] && !sclk_q[2];
    assign sd        = sd_q[1];
    assign addr_ok   = 32'(shift_q[15:8]) < NREG;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StWaitIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitIdle: if (cs_high) state_d = StIdle;
            StIdle:     if (cs_fall) state_d = StShift;
            StShift: begin
                if (cs_rise) state_d = StIdle;
                else if (sclk_rise && cnt_q == 5'd15) state_d = StCommit;
            end
            StCommit:   state_d = StTail;
            StTail:     if (cs_high) state_d = StIdle;
            default:    state_d = StWaitIdle;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tail_d    = tail_q;
        wr_en_d   = 1'b0;
        ferr_d    = 1'b0;
        aerr_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (cs_rise) begin
                    ferr_d = (cnt_q != 5'd0);
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], sd};
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            StCommit: begin
                wr_en_d   = 1'b1;
                wr_addr_d = shift_q[15:8];
                wr_data_d = shift_q[7:0];
                aerr_d    = !addr_ok;
                reg_we    = addr_ok;
                tail_d    = 1'b0;
            end
            StTail: begin
                // Level check also covers a CS rise that landed during the COMMIT cycle
                if (cs_high)        ferr_d = tail_q;
                else if (sclk_rise) tail_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            tail_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            ferr_q    <= 1'b0;
            aerr_q    <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tail_q    <= tail_d;
            wr_en_q   <= wr_en_d;
            ferr_q    <= ferr_d;
            aerr_q    <= aerr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (reg_we && shift_q[15:8] == 8'(i)) regs_q[i*8 +: 8] <= shift_q[7:0];
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = ferr_q;
    assign addr_err  = aerr_q;
    assign regs      = regs_q;

endmodule
